// File: rtl/arb_wordmux.sv
// arb_wordmux: N-channel word multiplexer with round-robin or fixed-priority
// arbitration, optional grant lock and a one-entry registered output stage.
module arb_wordmux #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = 2,
  parameter int unsigned MODE     = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS-1:0]       i_valid,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  output logic [CHANNELS-1:0]       o_ready,
  input  logic                      i_lock,
  output logic                      o_valid,
  output logic [WIDTH-1:0]          o_data,
  output logic [SELW-1:0]           o_chan,
  input  logic                      i_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  last;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  next_ptr;
  logic [WIDTH-1:0] word;
  logic             found;
  logic             lock_hit;
  logic             any_valid;
  logic             load;
  logic             xfer;

  // Handshake qualifiers: the register can take a word when empty or draining.
  always_comb begin
    any_valid = |i_valid;
    load      = !o_valid || i_ready;
    xfer      = !i_rst && load && any_valid;
  end

  // Lock applies only while the last-granted channel is still requesting.
  always_comb begin
    lock_hit = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (SELW'(k) == last && i_valid[k]) begin
        lock_hit = 1'b1;
      end
    end
  end

  // Grant selection; round-robin is split into two ascending scans
  // (ptr..CHANNELS-1, then 0..ptr-1) instead of a modular rotate.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (i_lock && lock_hit) begin
      grant = last;
      found = 1'b1;
    end else if (MODE == 1) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (!found && i_valid[k]) begin
          grant = SELW'(k);
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (!found && i_valid[k] && SELW'(k) >= ptr) begin
          grant = SELW'(k);
          found = 1'b1;
        end
      end
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (!found && i_valid[k] && SELW'(k) < ptr) begin
          grant = SELW'(k);
          found = 1'b1;
        end
      end
    end
  end

  // Word of the granted channel and the pointer value following it.
  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (SELW'(k) == grant) begin
        word = i_data[k*WIDTH +: WIDTH];
      end
    end
    next_ptr = (grant == SELW'(CHANNELS - 1)) ? '0 : grant + SELW'(1);
  end

  // One-hot accept towards the granted producer.
  always_comb begin
    o_ready = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      o_ready[k] = xfer && (SELW'(k) == grant);
    end
  end

  // Output register, grant history and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_chan  <= '0;
      ptr     <= '0;
      last    <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_data  <= word;
      o_chan  <= grant;
      last    <= grant;
      if (MODE == 0) begin
        ptr <= next_ptr;
      end
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_wordmux.sv
// tb_arb_wordmux: three arb_wordmux instances (4-ch round-robin, 4-ch fixed
// priority, 3-ch round-robin) checked against a cycle-level reference model.
module tb_arb_wordmux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  va [3];
  logic [63:0] da [3];
  logic        lk [3];
  logic        ir [3];

  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2;
  logic        ov0, ov1, ov2;
  logic [15:0] od0, od1, od2;
  logic [1:0]  oc0, oc1, oc2;

  int pass_cnt = 0;
  int total    = 0;

  // Reference model state
  int          m_ptr [3];
  int          m_last[3];
  int          m_ov  [3];
  int          m_oc  [3];
  logic [15:0] m_od  [3];

  // Gathered DUT outputs
  logic [3:0]  a_rdy [3];
  logic        a_ov  [3];
  logic [15:0] a_od  [3];
  logic [1:0]  a_oc  [3];

  arb_wordmux #(.WIDTH(16), .CHANNELS(4), .SELW(2), .MODE(0)) dut_rr (
    .i_clk(clk), .i_rst(rst), .i_valid(va[0]), .i_data(da[0]), .o_ready(rdy0),
    .i_lock(lk[0]), .o_valid(ov0), .o_data(od0), .o_chan(oc0), .i_ready(ir[0]));

  arb_wordmux #(.WIDTH(16), .CHANNELS(4), .SELW(2), .MODE(1)) dut_fp (
    .i_clk(clk), .i_rst(rst), .i_valid(va[1]), .i_data(da[1]), .o_ready(rdy1),
    .i_lock(lk[1]), .o_valid(ov1), .o_data(od1), .o_chan(oc1), .i_ready(ir[1]));

  arb_wordmux #(.WIDTH(16), .CHANNELS(3), .SELW(2), .MODE(0)) dut_c3 (
    .i_clk(clk), .i_rst(rst), .i_valid(va[2][2:0]), .i_data(da[2][47:0]), .o_ready(rdy2),
    .i_lock(lk[2]), .o_valid(ov2), .o_data(od2), .o_chan(oc2), .i_ready(ir[2]));

  function automatic int nch(int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic int mode_of(int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic bit req(int d, int k);
    return ((va[d] >> k) & 4'd1) != 4'd0;
  endfunction

  // Channel chosen by the arbitration rules, or -1 when nobody requests.
  function automatic int exp_grant(int d);
    int n;
    n = nch(d);
    if (lk[d] && req(d, m_last[d])) return m_last[d];
    if (mode_of(d) == 1) begin
      for (int k = 0; k < n; k++) if (req(d, k)) return k;
    end else begin
      for (int off = 0; off < n; off++) begin
        if (req(d, (m_ptr[d] + off) % n)) return (m_ptr[d] + off) % n;
      end
    end
    return -1;
  endfunction

  task automatic gather();
    a_rdy[0] = rdy0; a_rdy[1] = rdy1; a_rdy[2] = {1'b0, rdy2};
    a_ov[0]  = ov0;  a_ov[1]  = ov1;  a_ov[2]  = ov2;
    a_od[0]  = od0;  a_od[1]  = od1;  a_od[2]  = od2;
    a_oc[0]  = oc0;  a_oc[1]  = oc1;  a_oc[2]  = oc2;
  endtask

  // One clock: accept vectors checked mid-cycle, registered outputs after the edge.
  task automatic run_cycle();
    int       g [3];
    logic [3:0] er [3];
    @(negedge clk);
    gather();
    for (int d = 0; d < 3; d++) begin
      g[d] = exp_grant(d);
      if (rst || (m_ov[d] != 0 && !ir[d]) || g[d] < 0) er[d] = 4'd0;
      else er[d] = 4'(1 << g[d]);
      total++;
      if (a_rdy[d] !== er[d]) $display("FAIL ready dut%0d: got %b want %b", d, a_rdy[d], er[d]);
      else pass_cnt++;
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_ov[d] = 0; m_oc[d] = 0; m_od[d] = 16'h0; m_ptr[d] = 0; m_last[d] = 0;
      end else if (er[d] != 4'd0) begin
        m_ov[d] = 1; m_oc[d] = g[d]; m_last[d] = g[d];
        m_od[d] = 16'(da[d] >> (16 * g[d]));
        if (mode_of(d) == 0) m_ptr[d] = (g[d] + 1) % nch(d);
      end else if (m_ov[d] != 0 && ir[d]) begin
        m_ov[d] = 0;
      end
    end
    #1;
    gather();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (a_ov[d] !== (m_ov[d] != 0)) $display("FAIL o_valid dut%0d: got %b want %0d", d, a_ov[d], m_ov[d]);
      else pass_cnt++;
      total++;
      if (a_od[d] !== m_od[d]) $display("FAIL o_data dut%0d: got %h want %h", d, a_od[d], m_od[d]);
      else pass_cnt++;
      total++;
      if (a_oc[d] !== 2'(m_oc[d])) $display("FAIL o_chan dut%0d: got %0d want %0d", d, a_oc[d], m_oc[d]);
      else pass_cnt++;
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      va[d] = 4'd0; lk[d] = 1'b0; ir[d] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    do_reset();
    va[0] = 4'hF;
    for (int i = 0; i < 3; i++) run_cycle();
    ir[0] = 1'b0;
    for (int i = 0; i < 2; i++) run_cycle();
    rst = 1'b1;
    run_cycle();
    total++;
    if (ov0 !== 1'b0 || od0 !== 16'h0 || oc0 !== 2'd0)
      $display("FAIL reset_state: got v=%b d=%h c=%0d want 0/0000/0", ov0, od0, oc0);
    else pass_cnt++;
    total++;
    if (rdy0 !== 4'd0) $display("FAIL reset_ready: got %b want 0000", rdy0);
    else pass_cnt++;
    rst = 1'b0;
    ir[0] = 1'b1;
    run_cycle();
    total++;
    if (ov0 !== 1'b1 || oc0 !== 2'd0) $display("FAIL first_grant: got v=%b c=%0d want 1/0", ov0, oc0);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    idle_all();
    do_reset();
    va[0] = 4'hF;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      total++;
      if (ov0 !== 1'b1 || oc0 !== 2'(i % 4) || od0 !== 16'(16'h00A0 + i % 4))
        $display("FAIL rr_seq[%0d]: got v=%b c=%0d d=%h want 1/%0d/%h", i, ov0, oc0, od0, i % 4, 16'h00A0 + i % 4);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] sd;
    logic [1:0]  sc;
    int          want;
    sd = od0; sc = oc0;
    ir[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      total++;
      if (ov0 !== 1'b1 || od0 !== sd || oc0 !== sc || rdy0 !== 4'd0)
        $display("FAIL bp_hold[%0d]: got v=%b d=%h c=%0d r=%b want 1/%h/%0d/0000", i, ov0, od0, oc0, rdy0, sd, sc);
      else pass_cnt++;
    end
    want = ((int'(sc) + 1) % 4 == 1) ? 1 : 2;
    va[0] = 4'b0110;
    ir[0] = 1'b1;
    run_cycle();
    total++;
    if (oc0 !== 2'(want)) $display("FAIL bp_resume: got %0d want %0d", oc0, want);
    else pass_cnt++;
  endtask

  task automatic test_fixed_priority();
    idle_all();
    do_reset();
    va[1] = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      total++;
      if (ov1 !== 1'b1 || oc1 !== 2'd0) $display("FAIL fp_low[%0d]: got v=%b c=%0d want 1/0", i, ov1, oc1);
      else pass_cnt++;
    end
    va[1] = 4'b0100;
    run_cycle();
    total++;
    if (oc1 !== 2'd2) $display("FAIL fp_next: got %0d want 2", oc1);
    else pass_cnt++;
  endtask

  task automatic test_lock();
    int order [3] = '{3, 0, 1};
    idle_all();
    do_reset();
    va[0] = 4'b0100;
    run_cycle();
    total++;
    if (oc0 !== 2'd2) $display("FAIL lock_pre: got %0d want 2", oc0);
    else pass_cnt++;
    lk[0] = 1'b1;
    va[0] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      total++;
      if (oc0 !== 2'd2) $display("FAIL lock_hold[%0d]: got %0d want 2", i, oc0);
      else pass_cnt++;
    end
    lk[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      total++;
      if (oc0 !== 2'(order[i])) $display("FAIL lock_resume[%0d]: got %0d want %0d", i, oc0, order[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    idle_all();
    do_reset();
    va[2] = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      total++;
      if (ov2 !== 1'b1 || oc2 !== ((i % 2 == 1) ? 2'd2 : 2'd0))
        $display("FAIL wrap[%0d]: got v=%b c=%0d want 1/%0d", i, ov2, oc2, (i % 2 == 1) ? 2 : 0);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int d = 0; d < 3; d++) begin
        va[d] = 4'($urandom);
        if (d == 2) va[d][3] = 1'b0;
        da[d] = {$urandom, $urandom};
        lk[d] = ($urandom_range(0, 3) == 0);
        ir[d] = ($urandom_range(0, 3) != 0);
      end
      run_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      m_ptr[d] = 0; m_last[d] = 0; m_ov[d] = 0; m_oc[d] = 0; m_od[d] = 16'h0;
    end
    da[0] = 64'h00A3_00A2_00A1_00A0;
    da[1] = 64'h00B3_00B2_00B1_00B0;
    da[2] = 64'h0000_00C2_00C1_00C0;
    idle_all();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_fixed_priority();
    test_lock();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
